// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the fetch/execute control sequencer: opcodes,
// function/shift codes, control-word layout and FSM states.
package control_sequencer_pkg;

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  localparam logic [3:0] OP_MOVA = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_MOVB = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_ADI  = 4'hB;
  localparam logic [3:0] OP_LSR  = 4'hC;
  localparam logic [3:0] OP_LSL  = 4'hD;
  localparam logic [3:0] OP_BR   = 4'hE;
  localparam logic [3:0] OP_LD   = 4'hF;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_INC  = 4'b0001;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_DEC  = 4'b0110;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;

  localparam logic [2:0] SS_LSR = 3'b000;
  localparam logic [2:0] SS_LSL = 3'b001;

  // Packed field order fixes the 26-bit control word layout, MSB first.
  typedef struct packed {
    logic [3:0] da;
    logic [3:0] aa;
    logic [3:0] ba;
    logic       mb;
    logic [3:0] fs;
    logic [2:0] ss;
    logic [3:0] sa;
    logic       md;
    logic       rw;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational decode of the instruction register into the datapath
// control word, constant and sequencing hints.
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        dmem_ack,
  output logic [25:0] control,
  output logic [15:0] constant,
  output logic        flag_update,
  output logic        is_branch,
  output logic        is_load
);

  logic [3:0] op, dr, sa, sb;
  ctrl_t      dec;

  assign op = ir[15:12];
  assign dr = ir[11:8];
  assign sa = ir[7:4];
  assign sb = ir[3:0];

  always_comb begin
    dec         = '0;
    dec.da      = dr;
    dec.rw      = 1'b1;
    constant    = '0;
    flag_update = 1'b0;
    is_branch   = 1'b0;
    is_load     = 1'b0;
    case (op)
      OP_MOVA: begin dec.aa = sa; dec.fs = FS_MOVA; end
      OP_INC:  begin dec.aa = sa; dec.fs = FS_INC;  flag_update = 1'b1; end
      OP_ADD:  begin dec.aa = sa; dec.ba = sb; dec.fs = FS_ADD; flag_update = 1'b1; end
      OP_SUB:  begin dec.aa = sa; dec.ba = sb; dec.fs = FS_SUB; flag_update = 1'b1; end
      OP_DEC:  begin dec.aa = sa; dec.fs = FS_DEC;  flag_update = 1'b1; end
      OP_AND:  begin dec.aa = sa; dec.ba = sb; dec.fs = FS_AND; flag_update = 1'b1; end
      OP_OR:   begin dec.aa = sa; dec.ba = sb; dec.fs = FS_OR;  flag_update = 1'b1; end
      OP_XOR:  begin dec.aa = sa; dec.ba = sb; dec.fs = FS_XOR; flag_update = 1'b1; end
      OP_NOT:  begin dec.aa = sa; dec.fs = FS_NOT;  flag_update = 1'b1; end
      OP_MOVB: begin dec.ba = sb; dec.fs = FS_MOVB; end
      OP_LDI: begin
        dec.mb   = 1'b1;
        dec.fs   = FS_MOVB;
        constant = {8'h00, sa, sb};
      end
      OP_ADI: begin
        dec.aa      = sa;
        dec.mb      = 1'b1;
        dec.fs      = FS_ADD;
        constant    = {12'h000, sb};
        flag_update = 1'b1;
      end
      OP_LSR:  begin dec.ba = sa; dec.ss = SS_LSR; dec.sa = sb; dec.fs = FS_MOVB; end
      OP_LSL:  begin dec.ba = sa; dec.ss = SS_LSL; dec.sa = sb; dec.fs = FS_MOVB; end
      OP_BR: begin
        dec       = '0;
        is_branch = 1'b1;
      end
      OP_LD: begin
        // Register write is held off until the load data arrives.
        dec.aa  = sa;
        dec.md  = 1'b1;
        dec.rw  = dmem_ack;
        is_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign control = dec;

endmodule

// File: rtl/control_sequencer.sv
// Two-state fetch/execute sequencer driving the 16-register datapath,
// with req/ack instruction and data-load ports.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic [15:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [15:0] busa,
  input  logic        v_in,
  input  logic        c_in,
  input  logic        n_in,
  input  logic        z_in,
  output logic [25:0] control,
  output logic [15:0] constant,
  output logic [15:0] pc,
  output logic [15:0] ir
);

  state_t      state;
  logic [3:0]  flags;  // {V,C,N,Z}
  logic [25:0] dec_control;
  logic [15:0] dec_constant;
  logic        flag_update, is_branch, is_load;
  logic        in_exec, taken;
  logic [15:0] pc_next;

  instr_decoder u_decoder (
    .ir          (ir),
    .dmem_ack    (dmem_ack),
    .control     (dec_control),
    .constant    (dec_constant),
    .flag_update (flag_update),
    .is_branch   (is_branch),
    .is_load     (is_load)
  );

  assign in_exec   = (state == S_EXEC);
  assign imem_req  = (state == S_FETCH) && en && !rst;
  assign imem_addr = pc;
  assign dmem_req  = in_exec && is_load;
  assign dmem_addr = busa;
  assign control   = in_exec ? dec_control  : '0;
  assign constant  = in_exec ? dec_constant : '0;

  // dr[1:0] indexes the latched flag vector directly: 0=Z, 1=N, 2=C, 3=V.
  assign taken   = is_branch && flags[ir[9:8]];
  assign pc_next = taken ? pc + 16'd1 + {{8{ir[7]}}, ir[7:0]} : pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            ir    <= imem_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load) begin
            if (dmem_ack) begin
              pc    <= pc + 16'd1;
              state <= S_FETCH;
            end
          end else begin
            if (flag_update) flags <= {v_in, c_in, n_in, z_in};
            pc    <= pc_next;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized instruction stream against a behavioural model.
module tb_control_sequencer;

  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, en, imem_req, imem_ack, dmem_req, dmem_ack;
  logic        v_in, c_in, n_in, z_in;
  logic [15:0] imem_addr, imem_data, dmem_addr, busa, constant, pc, ir;
  logic [25:0] control;

  int passed = 0;
  int total  = 0;

  logic [15:0] mpc;
  logic [3:0]  mflags;  // {V,C,N,Z}

  control_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .busa(busa),
    .v_in(v_in), .c_in(c_in), .n_in(n_in), .z_in(z_in),
    .control(control), .constant(constant), .pc(pc), .ir(ir)
  );

  always #5 clk = ~clk;

  // Expected {control, constant} for an instruction in EXEC.
  function automatic logic [41:0] ref_word(input logic [15:0] ins, input logic ack);
    logic [63:0] fs_tab;
    logic [15:0] use_a, use_b;
    logic [3:0]  op, dr, ra, rb, aa, ba, fs, sh;
    logic [2:0]  ss;
    logic        mb, md, rw;
    logic [15:0] k;
    fs_tab = 64'h00CC_2CCB_A986_5210;
    use_a  = 16'h89FF;
    use_b  = 16'h02EC;
    op = ins[15:12]; dr = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
    if (op == 4'hE) return '0;
    fs = fs_tab[op*4 +: 4];
    aa = use_a[op] ? ra : 4'h0;
    ba = use_b[op] ? rb : ((op == 4'hC || op == 4'hD) ? ra : 4'h0);
    sh = (op == 4'hC || op == 4'hD) ? rb : 4'h0;
    ss = (op == 4'hD) ? 3'd1 : 3'd0;
    mb = (op == 4'hA || op == 4'hB);
    md = (op == 4'hF);
    rw = (op == 4'hF) ? ack : 1'b1;
    k  = (op == 4'hA) ? {8'h00, ins[7:0]} : ((op == 4'hB) ? {12'h000, rb} : 16'h0000);
    return {dr, aa, ba, mb, fs, ss, sh, md, rw, k};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0;
    busa = '0; {v_in, c_in, n_in, z_in} = 4'b0000;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic fetch(input logic [15:0] ins);
    en = 1'b1; imem_ack = 1'b1; imem_data = ins;
    tick();
    imem_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; imem_ack = 1'b1; imem_data = 16'h1234; dmem_ack = 1'b0;
    busa = '0; {v_in, c_in, n_in, z_in} = 4'b0000;
    tick(); tick();
    total++; if (pc !== RPC) $display("FAIL reset_pc got %h want %h", pc, RPC); else passed++;
    total++; if (ir !== 16'h0) $display("FAIL reset_ir got %h want 0000", ir); else passed++;
    total++; if ({control, constant} !== 42'h0) $display("FAIL reset_ctrl got %h/%h want 0/0", control, constant); else passed++;
    total++; if ({imem_req, dmem_req} !== 2'b00) $display("FAIL reset_reqs got %b want 00", {imem_req, dmem_req}); else passed++;
    do_reset();
  endtask

  task automatic test_ldi();
    do_reset();
    en = 1'b1; imem_ack = 1'b1; imem_data = 16'hA35A;
    #1;
    total++; if ({imem_req, imem_addr, control} !== {1'b1, 16'h0000, 26'h0})
      $display("FAIL ldi_fetch got %b/%h/%h want 1/0000/0", imem_req, imem_addr, control); else passed++;
    tick();
    total++; if ({control, constant} !== {26'h0C03801, 16'h005A})
      $display("FAIL ldi_exec got %h/%h want 0c03801/005a", control, constant); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL ldi_exec_noreq got %b want 0", imem_req); else passed++;
    tick();
    total++; if ({pc, control} !== {16'h0001, 26'h0}) $display("FAIL ldi_pc1 got %h/%h want 0001/0", pc, control); else passed++;
    tick(); tick();
    total++; if (pc !== 16'h0002) $display("FAIL ldi_two_cycle got %h want 0002", pc); else passed++;
    imem_ack = 1'b0;
  endtask

  task automatic test_sub_branch();
    do_reset();
    fetch(16'h3122);
    z_in = 1'b1; #1;
    total++; if (control !== 26'h0488A01) $display("FAIL sub_ctrl got %h want 0488a01", control); else passed++;
    tick();
    z_in = 1'b0;
    fetch(16'hE0FD);
    total++; if ({control, constant} !== 42'h0) $display("FAIL br_ctrl got %h/%h want 0/0", control, constant); else passed++;
    tick();
    total++; if (pc !== 16'hFFFF) $display("FAIL br_taken_pc got %h want ffff", pc); else passed++;
    fetch(16'hA000);
    tick();
    total++; if (pc !== 16'h0000) $display("FAIL pc_wrap got %h want 0000", pc); else passed++;
  endtask

  task automatic test_br_not_taken();
    do_reset();
    fetch(16'hE205);
    total++; if ({control, constant} !== 42'h0) $display("FAIL brc_ctrl got %h/%h want 0/0", control, constant); else passed++;
    tick();
    total++; if (pc !== 16'h0001) $display("FAIL brc_pc got %h want 0001", pc); else passed++;
  endtask

  task automatic test_ld_stall();
    int hi;
    do_reset();
    hi = 0;
    fetch(16'hF450);
    for (int i = 0; i < 3; i++) begin
      busa = 16'($urandom); #1;
      if (dmem_req === 1'b1) hi++;
      total++; if ({dmem_addr, control, pc} !== {busa, 26'h1140002, 16'h0000})
        $display("FAIL ld_stall got %h/%h/%h want %h/1140002/0000", dmem_addr, control, pc, busa); else passed++;
      tick();
    end
    dmem_ack = 1'b1; #1;
    if (dmem_req === 1'b1) hi++;
    total++; if (control !== 26'h1140003) $display("FAIL ld_ack_ctrl got %h want 1140003", control); else passed++;
    tick();
    dmem_ack = 1'b0; #1;
    total++; if (hi !== 4) $display("FAIL ld_req_cycles got %0d want 4", hi); else passed++;
    total++; if ({pc, dmem_req} !== {16'h0001, 1'b0}) $display("FAIL ld_done got %h/%b want 0001/0", pc, dmem_req); else passed++;
  endtask

  task automatic test_lsl();
    do_reset();
    fetch(16'h3122);
    z_in = 1'b1;
    tick();
    z_in = 1'b0;
    fetch(16'hD724);
    total++; if (control !== 26'h1C09851) $display("FAIL lsl_ctrl got %h want 1c09851", control); else passed++;
    tick();
    fetch(16'hE002);
    tick();
    total++; if (pc !== 16'h0005) $display("FAIL lsl_flags_kept got %h want 0005", pc); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    fetch(16'hF450);
    tick(); tick();
    en = 1'b0; rst = 1'b1; dmem_ack = 1'b1;
    tick();
    rst = 1'b0; dmem_ack = 1'b0; #1;
    total++; if ({pc, ir, control, dmem_req} !== {RPC, 16'h0, 26'h0, 1'b0})
      $display("FAIL rst_stall got %h/%h/%h/%b want %h/0000/0/0", pc, ir, control, dmem_req, RPC); else passed++;
    en = 1'b1; #1;
    total++; if (imem_req !== 1'b1) $display("FAIL rst_stall_fetch got %b want 1", imem_req); else passed++;
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b0; imem_ack = 1'b1; imem_data = 16'hA35A; dmem_ack = 1'b1;
    tick(); tick(); tick();
    total++; if ({imem_req, pc, ir} !== {1'b0, 16'h0000, 16'h0000})
      $display("FAIL en_low got %b/%h/%h want 0/0000/0000", imem_req, pc, ir); else passed++;
    dmem_ack = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0; imem_ack = 1'b0;
    total++; if ({ir, control} !== {16'hA35A, 26'h0C03801}) $display("FAIL en_resume got %h/%h want a35a/0c03801", ir, control); else passed++;
    tick();
    total++; if ({pc, imem_req} !== {16'h0001, 1'b0}) $display("FAIL en_exec_completes got %h/%b want 0001/0", pc, imem_req); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [41:0] w;
    logic [3:0]  op;
    logic        cond;
    int          waits;
    do_reset();
    mpc = RPC; mflags = 4'b0000;
    for (int n = 0; n < 80; n++) begin
      en = 1'b1; imem_ack = 1'b0;
      waits = $urandom_range(0, 2);
      for (int i = 0; i < waits; i++) begin
        #1;
        total++; if ({imem_req, imem_addr, control} !== {1'b1, mpc, 26'h0})
          $display("FAIL rnd_fetch_wait got %b/%h/%h want 1/%h/0", imem_req, imem_addr, control, mpc); else passed++;
        tick();
      end
      ins = 16'($urandom);
      op  = ins[15:12];
      fetch(ins);
      {v_in, c_in, n_in, z_in} = 4'($urandom);
      busa = 16'($urandom); dmem_ack = 1'b0;
      if (op == 4'hF) begin
        waits = $urandom_range(0, 3);
        for (int i = 0; i < waits; i++) begin
          #1; w = ref_word(ins, 1'b0);
          total++; if ({control, constant, dmem_req, dmem_addr} !== {w, 1'b1, busa})
            $display("FAIL rnd_ld_stall ins=%h got %h/%h/%b want %h/1", ins, control, constant, dmem_req, w); else passed++;
          tick();
        end
        dmem_ack = 1'b1; #1; w = ref_word(ins, 1'b1);
        total++; if ({control, constant, dmem_req} !== {w, 1'b1})
          $display("FAIL rnd_ld_ack ins=%h got %h/%h want %h", ins, control, constant, w); else passed++;
        tick();
        dmem_ack = 1'b0;
        mpc = mpc + 16'd1;
      end else begin
        #1; w = ref_word(ins, 1'b0);
        total++; if ({control, constant, dmem_req} !== {w, 1'b0})
          $display("FAIL rnd_exec ins=%h got %h/%h/%b want %h/0", ins, control, constant, dmem_req, w); else passed++;
        case (ins[9:8])
          2'd0: cond = mflags[0];
          2'd1: cond = mflags[1];
          2'd2: cond = mflags[2];
          default: cond = mflags[3];
        endcase
        if (op == 4'hE && cond) mpc = mpc + 16'd1 + {{8{ins[7]}}, ins[7:0]};
        else mpc = mpc + 16'd1;
        if ((op >= 4'h1 && op <= 4'h8) || op == 4'hB) mflags = {v_in, c_in, n_in, z_in};
        tick();
      end
      total++; if (pc !== mpc) $display("FAIL rnd_pc ins=%h got %h want %h", ins, pc, mpc); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_sub_branch();
    test_br_not_taken();
    test_ld_stall();
    test_lsl();
    test_reset_mid_stall();
    test_en_low();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
